odeme: RTL and testbench
========================

ODEME -- requirements
Module: odeme

Interface
REQ-001 SHALL provide parameter UCRET_W, default 8, width of the fee input.
REQ-002 SHALL provide parameter BAKIYE_W, default 9, width of the balance input/output; BAKIYE_W >= UCRET_W.
REQ-003 SHALL have port saat  input  1  system clock, all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port basla  input  1  transaction request, sampled every rising edge.
REQ-006 SHALL have port ucret  input  UCRET_W  fee to charge, unsigned.
REQ-007 SHALL have port bakiye  input  BAKIYE_W  current balance, unsigned.
REQ-008 SHALL have port onay  output  1  payment approved flag, registered.
REQ-009 SHALL have port k_bakiye  output  BAKIYE_W  remaining balance, registered.
REQ-010 SHALL have port bitti  output  1  transaction complete flag, registered.

Function
REQ-011 SHALL implement a two-state FSM: BOSTA (idle) and SONUC (result valid).
REQ-012 On a rising edge with reset=0 and basla=1, SHALL capture ucret/bakiye, enter SONUC and update outputs; latency is exactly one clock edge.
REQ-013 Approval rule: onay=1 when bakiye >= zero-extended ucret; k_bakiye = bakiye - ucret, computed at BAKIYE_W bits with no wrap.
REQ-014 Decline rule: when bakiye < ucret, onay=0 and k_bakiye = bakiye, unchanged.
REQ-015 Equality (bakiye == ucret) SHALL approve with k_bakiye = 0; ucret = 0 SHALL approve with k_bakiye = bakiye.
REQ-016 bitti SHALL be 1 for each cycle following an edge where basla=1, otherwise 0; basla held high SHALL start a new transaction on every edge.
REQ-017 On an edge with basla=0, SHALL go to BOSTA, clear bitti, and hold onay and k_bakiye at their last values.
REQ-018 ucret/bakiye changes while basla=0 SHALL have no effect on any output.

Reset
REQ-019 On a rising edge with reset=1: state=BOSTA, onay=0, k_bakiye=0, bitti=0.
REQ-020 reset SHALL take priority over basla on the same edge, including mid-transaction; the aborted request is discarded.
REQ-021 Reset asserted for any number of cycles SHALL hold all outputs at reset values; operation resumes on the first edge with reset=0.

Configuration
REQ-022 Macro ODEME_STATS_EN SHALL, when defined, add outputs onay_sayac and red_sayac (16 bits each), counting approved and declined transactions.
REQ-023 Both counters SHALL saturate at 0xFFFF and clear on reset.
REQ-024 Without ODEME_STATS_EN, the counters and ports SHALL be absent; all other behaviour is identical.

Structure
REQ-025 Package odeme_pkg SHALL hold the default width constants, the FSM state enum (BOSTA, SONUC) and the stats counter width (16).
REQ-026 Sub-module odeme_karsilastir SHALL contain the purely combinational compare/subtract (inputs ucret, bakiye; outputs yeterli, kalan); odeme registers its results.

Verification
REQ-027 reset=0, basla=1, ucret=14, bakiye=45, one edge -> onay=1, k_bakiye=31, bitti=1.
REQ-028 reset held 55 cycles, then basla=0, ucret=56, bakiye=13, one edge -> bitti=0; then basla=0, ucret=22, bakiye=99 -> bitti=0, onay and k_bakiye unchanged.
REQ-029 basla=1, ucret=77, bakiye=87 -> onay=1, k_bakiye=10, bitti=1.
REQ-030 reset pulse for 1 cycle, then basla=1, ucret=69, bakiye=11 -> onay=0, k_bakiye=11, bitti=1.
REQ-031 basla=1, ucret=255, bakiye=255 -> onay=1, k_bakiye=0; ucret=0, bakiye=511 -> onay=1, k_bakiye=511.
REQ-032 reset=1 and basla=1 on the same edge -> onay=0, k_bakiye=0, bitti=0; with ODEME_STATS_EN, 3 approvals and 1 decline -> onay_sayac=3, red_sayac=1.

Source files
------------

// File: rtl/odeme_pkg.sv
// odeme_pkg -- shared constants and types for the payment block.
//   UCRET_W_DEF / BAKIYE_W_DEF : default fee / balance widths
//   STATS_W                    : width of the optional statistics counters
//   durum_t                    : FSM state (BOSTA idle, SONUC result valid)
//   sat_inc                    : saturating increment for the counters
package odeme_pkg;
  localparam int UCRET_W_DEF  = 8;
  localparam int BAKIYE_W_DEF = 9;
  localparam int STATS_W      = 16;

  typedef enum logic {BOSTA = 1'b0, SONUC = 1'b1} durum_t;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == '1) ? v : v + STATS_W'(1);
  endfunction
endpackage

// File: rtl/odeme_if.sv
// odeme_if -- request/result bundle of the payment block.
//   basla    : transaction request (master -> slave)
//   ucret    : fee, UCRET_W bits (master -> slave)
//   bakiye   : balance, BAKIYE_W bits (master -> slave)
//   onay     : approved flag (slave -> master)
//   k_bakiye : remaining balance (slave -> master)
//   bitti    : transaction complete (slave -> master)
interface odeme_if
  import odeme_pkg::*;
#(
  parameter int UCRET_W  = UCRET_W_DEF,
  parameter int BAKIYE_W = BAKIYE_W_DEF
);
  logic                basla;
  logic [UCRET_W-1:0]  ucret;
  logic [BAKIYE_W-1:0] bakiye;
  logic                onay;
  logic [BAKIYE_W-1:0] k_bakiye;
  logic                bitti;

  modport master (output basla, ucret, bakiye, input onay, k_bakiye, bitti);
  modport slave  (input basla, ucret, bakiye, output onay, k_bakiye, bitti);
endinterface

// File: rtl/odeme_karsilastir.sv
// odeme_karsilastir -- combinational affordability check.
//   ucret   : fee, zero-extended to the balance width before comparing
//   bakiye  : balance
//   yeterli : 1 when the balance covers the fee
//   kalan   : balance after charging, or the untouched balance on decline
module odeme_karsilastir #(
  parameter int UCRET_W  = 8,
  parameter int BAKIYE_W = 9
) (
  input  logic [UCRET_W-1:0]  ucret,
  input  logic [BAKIYE_W-1:0] bakiye,
  output logic                yeterli,
  output logic [BAKIYE_W-1:0] kalan
);
  logic [BAKIYE_W-1:0] ucret_ext;

  assign ucret_ext = BAKIYE_W'(ucret);
  assign yeterli   = (bakiye >= ucret_ext);
  // Subtraction only taken when it cannot underflow.
  assign kalan     = yeterli ? (bakiye - ucret_ext) : bakiye;
endmodule

// File: rtl/odeme.sv
// odeme -- single-cycle payment approval.
//   saat   : clock, rising edge
//   reset  : synchronous active-high reset
//   bus    : odeme_if slave (basla/ucret/bakiye in, onay/k_bakiye/bitti out)
//   onay_sayac / red_sayac : approval / decline counters, saturating,
//            present only when ODEME_STATS_EN is defined
// Every edge with basla=1 charges the fee and shows the result the next
// cycle; edges with basla=0 keep the last result and drop bitti.
module odeme
  import odeme_pkg::*;
#(
  parameter int UCRET_W  = UCRET_W_DEF,
  parameter int BAKIYE_W = BAKIYE_W_DEF
) (
  input  logic               saat,
  input  logic               reset,
  odeme_if.slave             bus
`ifdef ODEME_STATS_EN
  ,
  output logic [STATS_W-1:0] onay_sayac,
  output logic [STATS_W-1:0] red_sayac
`endif
);
  durum_t              state_q, state_d;
  logic                onay_q, onay_d;
  logic [BAKIYE_W-1:0] k_bakiye_q, k_bakiye_d;
  logic                yeterli;
  logic [BAKIYE_W-1:0] kalan;

  odeme_karsilastir #(.UCRET_W(UCRET_W), .BAKIYE_W(BAKIYE_W)) u_kars (
    .ucret  (bus.ucret),
    .bakiye (bus.bakiye),
    .yeterli(yeterli),
    .kalan  (kalan)
  );

  // State register
  always_ff @(posedge saat) begin
    if (reset) state_q <= BOSTA;
    else       state_q <= state_d;
  end

  // Next state: every request (re)enters SONUC, anything else idles.
  always_comb begin
    state_d = bus.basla ? SONUC : BOSTA;
  end

  // Result outputs: load on a new transaction, otherwise hold.
  always_comb begin
    onay_d     = onay_q;
    k_bakiye_d = k_bakiye_q;
    if (state_d == SONUC) begin
      onay_d     = yeterli;
      k_bakiye_d = kalan;
    end
  end

  always_ff @(posedge saat) begin
    if (reset) begin
      onay_q     <= 1'b0;
      k_bakiye_q <= '0;
    end else begin
      onay_q     <= onay_d;
      k_bakiye_q <= k_bakiye_d;
    end
  end

  assign bus.onay     = onay_q;
  assign bus.k_bakiye = k_bakiye_q;
  // SONUC is entered exactly on request edges, so it doubles as bitti.
  assign bus.bitti    = (state_q == SONUC);

`ifdef ODEME_STATS_EN
  logic [STATS_W-1:0] onay_sayac_q, red_sayac_q;

  always_ff @(posedge saat) begin
    if (reset) begin
      onay_sayac_q <= '0;
      red_sayac_q  <= '0;
    end else if (bus.basla) begin
      if (yeterli) onay_sayac_q <= sat_inc(onay_sayac_q);
      else         red_sayac_q  <= sat_inc(red_sayac_q);
    end
  end

  assign onay_sayac = onay_sayac_q;
  assign red_sayac  = red_sayac_q;
`endif
endmodule

// File: tb/tb_odeme.sv
module tb_odeme;
  logic saat = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference state, derived from the payment rules
  int e_onay, e_kb, e_bitti, e_ok_cnt, e_red_cnt;

  always #5 saat = ~saat;

  odeme_if #(.UCRET_W(8), .BAKIYE_W(9)) bus ();

`ifdef ODEME_STATS_EN
  logic [15:0] onay_sayac, red_sayac;
`endif

  odeme #(.UCRET_W(8), .BAKIYE_W(9)) u_dut (
    .saat (saat),
    .reset(reset),
    .bus  (bus.slave)
`ifdef ODEME_STATS_EN
    ,
    .onay_sayac(onay_sayac),
    .red_sayac (red_sayac)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  // Apply one edge worth of inputs, advance the model, compare all outputs.
  task automatic step(input logic r, input logic b, input int u, input int k);
    @(negedge saat);
    reset     = r;
    bus.basla = b;
    bus.ucret = u[7:0];
    bus.bakiye = k[8:0];
    if (r) begin
      e_onay = 0; e_kb = 0; e_bitti = 0; e_ok_cnt = 0; e_red_cnt = 0;
    end else if (b) begin
      e_bitti = 1;
      if (k >= u) begin
        e_onay = 1; e_kb = k - u;
        if (e_ok_cnt < 65535) e_ok_cnt++;
      end else begin
        e_onay = 0; e_kb = k;
        if (e_red_cnt < 65535) e_red_cnt++;
      end
    end else begin
      e_bitti = 0;
    end
    @(posedge saat);
    #1;
    chk("bitti", 32'(bus.bitti), e_bitti);
    chk("onay", 32'(bus.onay), e_onay);
    chk("k_bakiye", 32'(bus.k_bakiye), e_kb);
`ifdef ODEME_STATS_EN
    chk("onay_sayac", 32'(onay_sayac), e_ok_cnt);
    chk("red_sayac", 32'(red_sayac), e_red_cnt);
`endif
  endtask

  initial begin
    int u, k;
    reset = 1'b1; bus.basla = 1'b0; bus.ucret = '0; bus.bakiye = '0;
    e_onay = 0; e_kb = 0; e_bitti = 0; e_ok_cnt = 0; e_red_cnt = 0;

    // Reset state
    repeat (3) step(1'b1, 1'b0, 0, 0);

    // Basic approval
    step(1'b0, 1'b1, 14, 45);
    chk("r027_onay", 32'(bus.onay), 1);
    chk("r027_kb", 32'(bus.k_bakiye), 31);
    chk("r027_bitti", 32'(bus.bitti), 1);

    // Long reset, then idle edges must not disturb outputs
    repeat (55) step(1'b1, 1'b1, 3, 100);
    step(1'b0, 1'b0, 56, 13);
    chk("r028_bitti0", 32'(bus.bitti), 0);
    step(1'b0, 1'b0, 22, 99);
    chk("r028_bitti1", 32'(bus.bitti), 0);
    chk("r028_onay_hold", 32'(bus.onay), 0);
    chk("r028_kb_hold", 32'(bus.k_bakiye), 0);

    step(1'b0, 1'b1, 77, 87);
    chk("r029_kb", 32'(bus.k_bakiye), 10);
    // Hold after a real result
    step(1'b0, 1'b0, 200, 5);
    chk("hold_onay", 32'(bus.onay), 1);
    chk("hold_kb", 32'(bus.k_bakiye), 10);

    // Decline after a one-cycle reset
    step(1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b1, 69, 11);
    chk("r030_onay", 32'(bus.onay), 0);
    chk("r030_kb", 32'(bus.k_bakiye), 11);
    chk("r030_bitti", 32'(bus.bitti), 1);

    // Equality and zero fee, back-to-back requests
    step(1'b0, 1'b1, 255, 255);
    chk("eq_kb", 32'(bus.k_bakiye), 0);
    step(1'b0, 1'b1, 0, 511);
    chk("zero_kb", 32'(bus.k_bakiye), 511);
    step(1'b0, 1'b1, 1, 0);
    chk("one_over", 32'(bus.onay), 0);

    // Reset beats a simultaneous request
    step(1'b1, 1'b1, 1, 200);
    chk("r032_kb", 32'(bus.k_bakiye), 0);
    chk("r032_bitti", 32'(bus.bitti), 0);

    // 3 approvals, 1 decline
    step(1'b0, 1'b1, 10, 20);
    step(1'b0, 1'b1, 20, 20);
    step(1'b0, 1'b1, 0, 0);
    step(1'b0, 1'b1, 30, 29);
`ifdef ODEME_STATS_EN
    chk("r032_onay_sayac", 32'(onay_sayac), 3);
    chk("r032_red_sayac", 32'(red_sayac), 1);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      u = $urandom_range(0, 255);
      k = ($urandom_range(0, 7) == 0) ? u : $urandom_range(0, 511);
      step($urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0, u, k);
    end

`ifdef ODEME_STATS_EN
    // Counter saturation
    step(1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 65540; i++) step(1'b0, 1'b1, 1, 2);
    chk("sat_onay", 32'(onay_sayac), 65535);
    step(1'b0, 1'b1, 9, 2);
    chk("sat_red", 32'(red_sayac), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
